bcd_time_counter: RTL and testbench

- Cascaded four-digit BCD counter that shows elapsed time as MM:SS.
- Consumes the one-cycle, once-per-second pulse from the seconds prescaler stage and replaces the single-digit 0-9 counter.
- Drives four BCD-to-7-segment decoders: HEX0 = seconds ones, HEX1 = seconds tens, HEX2 = minutes ones, HEX3 = minutes tens.
- Adds synchronous clear, preset load with validity checking, and a wrap pulse for chaining an hours stage.

---
 rtl/bcd_time_counter.sv | 130 +++++++++++++
 tb/tb_bcd_time_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// Four-digit BCD elapsed-time counter (MM:SS) advanced by a once-per-second tick,
// with synchronous clear, validated preset load and a wrap pulse for an hours stage.
module bcd_time_counter #(
  parameter int MAX_MIN = 59
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic        Tick,
  input  logic        Enable,
  input  logic        Clear,
  input  logic        Load,
  input  logic [15:0] LoadVal,
  output logic [3:0]  Sec0,
  output logic [3:0]  Sec1,
  output logic [3:0]  Min0,
  output logic [3:0]  Min1,
  output logic        Rollover,
  output logic        LoadErr
);

  generate
    if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max_min
      $error("bcd_time_counter: MAX_MIN must be within 1..99");
    end
  endgenerate

  localparam logic [3:0] MAX_MIN1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN0 = 4'(MAX_MIN % 10);
  localparam logic [7:0] MAX_MIN_VAL = 8'(MAX_MIN);

  logic [3:0] ld_sec0;
  logic [3:0] ld_sec1;
  logic [3:0] ld_min0;
  logic [3:0] ld_min1;
  logic [7:0] ld_min_val;
  logic       load_ok;

  assign ld_sec0 = LoadVal[3:0];
  assign ld_sec1 = LoadVal[7:4];
  assign ld_min0 = LoadVal[11:8];
  assign ld_min1 = LoadVal[15:12];

  // The decimal minutes product is only meaningful once both nibbles are known BCD.
  assign ld_min_val = ({4'd0, ld_min1} * 8'd10) + {4'd0, ld_min0};

  assign load_ok = (ld_sec0 <= 4'd9) && (ld_sec1 <= 4'd5) &&
                   (ld_min0 <= 4'd9) && (ld_min1 <= 4'd9) &&
                   (ld_min_val <= MAX_MIN_VAL);

  logic       sec0_carry;
  logic       sec1_carry;
  logic       min_at_max;
  logic       wrap;
  logic [3:0] inc_sec0;
  logic [3:0] inc_sec1;
  logic [3:0] inc_min0;
  logic [3:0] inc_min1;

  // Comparisons use >= so that every digit falls back into range from any state.
  assign sec0_carry = (Sec0 >= 4'd9);
  assign sec1_carry = sec0_carry && (Sec1 >= 4'd5);
  assign min_at_max = ({Min1, Min0} >= {MAX_MIN1, MAX_MIN0});
  assign wrap       = sec1_carry && min_at_max;

  always_comb begin
    inc_sec0 = Sec0;
    inc_sec1 = Sec1;
    inc_min0 = Min0;
    inc_min1 = Min1;

    inc_sec0 = sec0_carry ? 4'd0 : Sec0 + 4'd1;

    if (sec0_carry) begin
      inc_sec1 = (Sec1 >= 4'd5) ? 4'd0 : Sec1 + 4'd1;
    end

    if (sec1_carry) begin
      if (min_at_max) begin
        inc_min0 = 4'd0;
        inc_min1 = 4'd0;
      end else if (Min0 >= 4'd9) begin
        inc_min0 = 4'd0;
        inc_min1 = Min1 + 4'd1;
      end else begin
        inc_min0 = Min0 + 4'd1;
      end
    end
  end

  // Clear and Load both swallow a coincident Tick; nothing is deferred.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      Sec0     <= 4'd0;
      Sec1     <= 4'd0;
      Min0     <= 4'd0;
      Min1     <= 4'd0;
      Rollover <= 1'b0;
      LoadErr  <= 1'b0;
    end else if (Clear) begin
      Sec0     <= 4'd0;
      Sec1     <= 4'd0;
      Min0     <= 4'd0;
      Min1     <= 4'd0;
      Rollover <= 1'b0;
      LoadErr  <= 1'b0;
    end else if (Load) begin
      Rollover <= 1'b0;
      if (load_ok) begin
        Sec0    <= ld_sec0;
        Sec1    <= ld_sec1;
        Min0    <= ld_min0;
        Min1    <= ld_min1;
        LoadErr <= 1'b0;
      end else begin
        LoadErr <= 1'b1;
      end
    end else if (Tick && Enable) begin
      Sec0     <= inc_sec0;
      Sec1     <= inc_sec1;
      Min0     <= inc_min0;
      Min1     <= inc_min1;
      Rollover <= wrap;
      LoadErr  <= 1'b0;
    end else begin
      Rollover <= 1'b0;
      LoadErr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: two instances (MAX_MIN 59 and 15) share stimulus and are
// compared against an elapsed-seconds reference model.
module tb_bcd_time_counter;

  logic        clk;
  logic        rstn;
  logic        tick;
  logic        en;
  logic        clr;
  logic        ld;
  logic [15:0] lv;

  logic [3:0] s0_a, s1_a, m0_a, m1_a;
  logic       roll_a, err_a;
  logic [3:0] s0_b, s1_b, m0_b, m1_b;
  logic       roll_b, err_b;

  int checks = 0;
  int errors = 0;

  int max_min [2] = '{59, 15};
  int t_sec   [2];
  bit m_roll  [2];
  bit m_err   [2];

  bcd_time_counter #(.MAX_MIN(59)) dut59 (
    .CLOCK_50(clk), .Resetn(rstn), .Tick(tick), .Enable(en), .Clear(clr),
    .Load(ld), .LoadVal(lv),
    .Sec0(s0_a), .Sec1(s1_a), .Min0(m0_a), .Min1(m1_a),
    .Rollover(roll_a), .LoadErr(err_a)
  );

  bcd_time_counter #(.MAX_MIN(15)) dut15 (
    .CLOCK_50(clk), .Resetn(rstn), .Tick(tick), .Enable(en), .Clear(clr),
    .Load(ld), .LoadVal(lv),
    .Sec0(s0_b), .Sec1(s1_b), .Min0(m0_b), .Min1(m1_b),
    .Rollover(roll_b), .LoadErr(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit validLoad(input logic [15:0] v, input int mx);
    int d0, d1, d2, d3;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    d2 = int'(v[11:8]);
    d3 = int'(v[15:12]);
    return (d0 <= 9) && (d1 <= 5) && (d2 <= 9) && (d3 <= 9) && (d3 * 10 + d2 <= mx);
  endfunction

  function automatic logic [15:0] toDigits(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Model works in whole elapsed seconds; the wrap point is (MAX_MIN+1) minutes.
  task automatic modelStep(input int i);
    if (!rstn || clr) begin
      t_sec[i] = 0; m_roll[i] = 0; m_err[i] = 0;
    end else if (ld) begin
      m_roll[i] = 0;
      if (validLoad(lv, max_min[i])) begin
        t_sec[i] = (int'(lv[15:12]) * 10 + int'(lv[11:8])) * 60 +
                   int'(lv[7:4]) * 10 + int'(lv[3:0]);
        m_err[i] = 0;
      end else begin
        m_err[i] = 1;
      end
    end else if (tick && en) begin
      t_sec[i] = t_sec[i] + 1;
      m_roll[i] = (t_sec[i] == (max_min[i] + 1) * 60);
      if (m_roll[i]) t_sec[i] = 0;
      m_err[i] = 0;
    end else begin
      m_roll[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic applyStimulus(input bit rstn_v, input bit clr_v, input bit ld_v,
                               input logic [15:0] lv_v, input bit tick_v, input bit en_v);
    rstn = rstn_v; clr = clr_v; ld = ld_v; lv = lv_v; tick = tick_v; en = en_v;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] obs_d, exp_d;
    logic [1:0]  obs_f, exp_f;

    obs_d = {m1_a, m0_a, s1_a, s0_a};
    exp_d = toDigits(t_sec[0]);
    checks++;
    assert (obs_d === exp_d) else begin
      errors++;
      $error("[TB] FAIL %s max59 digits: observed %h expected %h", tag, obs_d, exp_d);
    end
    obs_f = {roll_a, err_a};
    exp_f = {m_roll[0], m_err[0]};
    checks++;
    assert (obs_f === exp_f) else begin
      errors++;
      $error("[TB] FAIL %s max59 {Rollover,LoadErr}: observed %b expected %b", tag, obs_f, exp_f);
    end

    obs_d = {m1_b, m0_b, s1_b, s0_b};
    exp_d = toDigits(t_sec[1]);
    checks++;
    assert (obs_d === exp_d) else begin
      errors++;
      $error("[TB] FAIL %s max15 digits: observed %h expected %h", tag, obs_d, exp_d);
    end
    obs_f = {roll_b, err_b};
    exp_f = {m_roll[1], m_err[1]};
    checks++;
    assert (obs_f === exp_f) else begin
      errors++;
      $error("[TB] FAIL %s max15 {Rollover,LoadErr}: observed %b expected %b", tag, obs_f, exp_f);
    end
  endtask

  initial begin
    logic [15:0] rv;
    int rm, rs;
    rstn = 1'b0; clr = 1'b0; ld = 1'b0; lv = 16'h0000; tick = 1'b0; en = 1'b0;
    t_sec = '{0, 0}; m_roll = '{0, 0}; m_err = '{0, 0};

    $display("[TB] reset with Tick/Load/Clear high");
    applyStimulus(0, 1, 1, 16'h1234, 1, 1); checkOutput("reset1");
    applyStimulus(0, 1, 1, 16'h1234, 1, 1); checkOutput("reset2");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 16'h0000, 1, 1);
    checkOutput("ten_ticks");

    $display("[TB] carry chain and rollover");
    applyStimulus(1, 0, 1, 16'h0959, 0, 1); checkOutput("load_0959");
    applyStimulus(1, 0, 0, 16'h0000, 1, 1); checkOutput("carry_to_1000");
    applyStimulus(1, 0, 1, 16'h5959, 0, 1); checkOutput("load_5959");
    applyStimulus(1, 0, 0, 16'h0000, 1, 1); checkOutput("wrap59");
    applyStimulus(1, 0, 0, 16'h0000, 0, 1); checkOutput("wrap59_pulse_end");

    $display("[TB] MAX_MIN 15 wrap and bound");
    applyStimulus(1, 0, 1, 16'h1559, 0, 1); checkOutput("load_1559");
    applyStimulus(1, 0, 0, 16'h0000, 1, 1); checkOutput("tick_1559");
    applyStimulus(1, 0, 1, 16'h1600, 0, 1); checkOutput("load_1600");
    applyStimulus(1, 0, 0, 16'h0000, 0, 1); checkOutput("after_1600");
    applyStimulus(1, 0, 1, 16'h0000, 0, 1); checkOutput("load_0000_no_roll");

    $display("[TB] invalid loads from 00:42");
    applyStimulus(1, 0, 1, 16'h0042, 0, 1); checkOutput("load_0042");
    applyStimulus(1, 0, 1, 16'h0A00, 0, 1); checkOutput("load_0A00");
    applyStimulus(1, 0, 0, 16'h0000, 0, 1); checkOutput("gap");
    applyStimulus(1, 0, 1, 16'h0060, 0, 1); checkOutput("load_0060");
    applyStimulus(1, 0, 0, 16'h0000, 0, 1); checkOutput("err_pulse_end");

    $display("[TB] gating and priority");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 16'h0000, 1, 0);
    checkOutput("enable_low");
    applyStimulus(1, 0, 1, 16'h1234, 0, 1); checkOutput("load_1234");
    applyStimulus(1, 1, 0, 16'h0000, 1, 1); checkOutput("clear_with_tick");
    applyStimulus(1, 0, 1, 16'h0100, 1, 1); checkOutput("load_with_tick");

    $display("[TB] sustained tick");
    applyStimulus(1, 0, 1, 16'h0058, 0, 1); checkOutput("load_0058");
    applyStimulus(1, 0, 0, 16'h0000, 1, 1); checkOutput("hold1");
    applyStimulus(1, 0, 0, 16'h0000, 1, 1); checkOutput("hold2");
    applyStimulus(1, 0, 0, 16'h0000, 1, 1); checkOutput("hold3");

    $display("[TB] mid-count reset");
    applyStimulus(0, 0, 1, 16'h0123, 1, 1); checkOutput("mid_reset");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      rm = int'($urandom_range(0, 20));
      rs = int'($urandom_range(0, 59));
      if ($urandom_range(0, 3) == 0) rv = 16'($urandom);
      else rv = {4'(rm / 10), 4'(rm % 10), 4'(rs / 10), 4'(rs % 10)};
      applyStimulus(($urandom_range(0, 60) != 0), ($urandom_range(0, 40) == 0),
                    ($urandom_range(0, 12) == 0), rv,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));
      checkOutput("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
